// File: rtl/vec_decode_seq.sv
// ============================================================================
// Module   : vec_decode_seq
// Purpose  : Registered decode-and-issue stage; vector ops become VLEN/LANES beats.
// Option   : VDEC_ILLEGAL_TRAP_EN drops opcode 111 and raises a sticky illegal_err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vec_decode_seq #(
  parameter int INSTR_W = 21,
  parameter int REG_AW  = 4,
  parameter int IMM_W   = 8,
  parameter int VLEN    = 16,
  parameter int LANES   = 4,
  localparam int NB     = VLEN / LANES,
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         ex_ctrl,
  output logic [3:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic [IMM_W-1:0]   imm,
  output logic [1:0]         reg_type,
  output logic               des_type,
  output logic [BW-1:0]      beat_idx,
  output logic               last_beat,
  output logic               illegal_err
);

  localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [4:0]          ex_ctrl_q, ex_ctrl_d;
  logic [3:0]          mem_ctrl_q, mem_ctrl_d;
  logic [1:0]          wb_ctrl_q, wb_ctrl_d;
  logic [REG_AW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [1:0]          reg_type_q, reg_type_d;
  logic                des_type_q, des_type_d;
  logic [BW-1:0]       beat_idx_q, beat_idx_d;
  logic                last_beat_q, last_beat_d;

  // Decoded view of the incoming instruction
  logic                w_funct, w_imm_flag, w_des;
  logic [2:0]          w_op;
  logic [1:0]          w_wb, w_rt;
  logic [REG_AW-1:0]   w_rd, w_rs1, w_rs2;
  logic [IMM_W-1:0]    w_imm;
  logic                w_drop;
`ifdef VDEC_ILLEGAL_TRAP_EN
  logic                w_illegal;
  logic                illegal_err_q, illegal_err_d;
`endif

  always_comb begin
    w_funct    = instr[INSTR_W-1];
    w_op       = instr[INSTR_W-2 -: 3];
    w_imm_flag = instr[INSTR_W-5];
    w_wb       = instr[INSTR_W-6 -: 2];
    w_rd       = '0;
    w_rs1      = '0;
    w_rs2      = '0;
    w_imm      = '0;
    w_rt       = 2'b00;
    w_des      = 1'b0;
`ifdef VDEC_ILLEGAL_TRAP_EN
    w_illegal  = 1'b0;
`endif
    if (w_funct) begin
      w_rd  = instr[INSTR_W-8 -: REG_AW];
      w_rs1 = instr[INSTR_W-8-REG_AW -: REG_AW];
      w_rt  = 2'b01;
      w_des = 1'b1;
    end else begin
      case (w_op)
        3'b000, 3'b010, 3'b011: begin
          w_rd  = instr[INSTR_W-8 -: REG_AW];
          w_imm = instr[IMM_W-1:0];
          w_rt  = 2'b10;
        end
        3'b001: begin
          w_rd  = instr[INSTR_W-8 -: REG_AW];
          w_rs1 = instr[INSTR_W-8-REG_AW -: REG_AW];
          w_rt  = 2'b10;
          w_des = 1'b1;
        end
        3'b100, 3'b110, 3'b101: begin
          w_rd  = instr[INSTR_W-8 -: REG_AW];
          w_rs1 = instr[INSTR_W-8-REG_AW -: REG_AW];
          w_rs2 = instr[INSTR_W-8-2*REG_AW -: REG_AW];
          w_rt  = (w_op == 3'b101) ? 2'b11 : 2'b01;
          w_des = 1'b1;
        end
        default: begin
          // opcode 111: issued as a NOP unless trapped
          w_wb = 2'b00;
`ifdef VDEC_ILLEGAL_TRAP_EN
          w_illegal = 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef VDEC_ILLEGAL_TRAP_EN
  assign w_drop = w_illegal;
`else
  assign w_drop = 1'b0;
`endif

  assign in_ready = (state_q == IDLE) || ((state_q == ISSUE) && last_beat_q && out_ready);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    mem_ctrl_d  = mem_ctrl_q;
    wb_ctrl_d   = wb_ctrl_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    reg_type_d  = reg_type_q;
    des_type_d  = des_type_q;
    beat_idx_d  = beat_idx_q;
    last_beat_d = last_beat_q;
`ifdef VDEC_ILLEGAL_TRAP_EN
    illegal_err_d = illegal_err_q;
`endif
    if (in_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      if (in_valid && w_drop) begin
`ifdef VDEC_ILLEGAL_TRAP_EN
        illegal_err_d = 1'b1;
`endif
      end else if (in_valid) begin
        state_d     = ISSUE;
        out_valid_d = 1'b1;
        ex_ctrl_d   = {w_funct, w_op, w_imm_flag};
        mem_ctrl_d  = {w_funct, w_op};
        wb_ctrl_d   = w_wb;
        rd_d        = w_rd;
        rs1_d       = w_rs1;
        rs2_d       = w_rs2;
        imm_d       = w_imm;
        reg_type_d  = w_rt;
        des_type_d  = w_des;
        beat_idx_d  = '0;
        last_beat_d = !w_des || (NB == 1);
      end
    end else if ((state_q == ISSUE) && out_ready) begin
      beat_idx_d  = beat_idx_q + 1'b1;
      last_beat_d = (beat_idx_q + 1'b1) == LAST_IDX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= '0;
      wb_ctrl_q   <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      reg_type_q  <= '0;
      des_type_q  <= 1'b0;
      beat_idx_q  <= '0;
      last_beat_q <= 1'b0;
`ifdef VDEC_ILLEGAL_TRAP_EN
      illegal_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      mem_ctrl_q  <= mem_ctrl_d;
      wb_ctrl_q   <= wb_ctrl_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      reg_type_q  <= reg_type_d;
      des_type_q  <= des_type_d;
      beat_idx_q  <= beat_idx_d;
      last_beat_q <= last_beat_d;
`ifdef VDEC_ILLEGAL_TRAP_EN
      illegal_err_q <= illegal_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;
  assign reg_type  = reg_type_q;
  assign des_type  = des_type_q;
  assign beat_idx  = beat_idx_q;
  assign last_beat = last_beat_q;
`ifdef VDEC_ILLEGAL_TRAP_EN
  assign illegal_err = illegal_err_q;
`else
  assign illegal_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_decode_seq.sv
// ============================================================================
// Module   : tb_vec_decode_seq
// Purpose  : Directed and random stimulus for vec_decode_seq against a micro-op queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vec_decode_seq;

  localparam int INSTR_W = 21;
  localparam int REG_AW  = 4;
  localparam int IMM_W   = 8;
  localparam int VLEN    = 16;
  localparam int LANES   = 4;
  localparam int NB      = VLEN / LANES;
  localparam int BW      = (NB > 1) ? $clog2(NB) : 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [4:0]         ex_ctrl;
  logic [3:0]         mem_ctrl;
  logic [1:0]         wb_ctrl;
  logic [REG_AW-1:0]  rd, rs1, rs2;
  logic [IMM_W-1:0]   imm;
  logic [1:0]         reg_type;
  logic               des_type;
  logic [BW-1:0]      beat_idx;
  logic               last_beat;
  logic               illegal_err;

  vec_decode_seq #(
    .INSTR_W(INSTR_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .VLEN(VLEN), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .reg_type(reg_type),
    .des_type(des_type), .beat_idx(beat_idx), .last_beat(last_beat), .illegal_err(illegal_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        ex;
    logic [3:0]        mem;
    logic [1:0]        wb;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        rt;
    logic              dt;
    logic [BW-1:0]     beat;
    logic              last;
  } uop_t;

  uop_t q[$];
  logic model_err = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input int f, input int op, input int immf, input int wb,
                                            input int r_d, input int r_s1, input int r_s2);
    logic [INSTR_W-1:0] v;
    v = '0;
    v[INSTR_W-1]                   = f[0];
    v[INSTR_W-2 -: 3]              = op[2:0];
    v[INSTR_W-5]                   = immf[0];
    v[INSTR_W-6 -: 2]              = wb[1:0];
    v[INSTR_W-8 -: REG_AW]         = r_d[REG_AW-1:0];
    v[INSTR_W-8-REG_AW -: REG_AW]  = r_s1[REG_AW-1:0];
    v[INSTR_W-8-2*REG_AW -: REG_AW] = r_s2[REG_AW-1:0];
    return v;
  endfunction

  function automatic logic [INSTR_W-1:0] mk_imm(input int op, input int wb, input int r_d, input int iv);
    logic [INSTR_W-1:0] v;
    v = mk(0, op, 1, wb, r_d, 0, 0);
    v[IMM_W-1:0] = iv[IMM_W-1:0];
    return v;
  endfunction

  // Expand an accepted instruction into the micro-ops the stage should issue
  task automatic model_accept(input logic [INSTR_W-1:0] ins);
    uop_t u;
    int   f, op, beats;
    f  = int'(ins[INSTR_W-1]);
    op = int'(ins[INSTR_W-2 -: 3]);
    u = '0;
    u.ex  = {ins[INSTR_W-1], ins[INSTR_W-2 -: 3], ins[INSTR_W-5]};
    u.mem = {ins[INSTR_W-1], ins[INSTR_W-2 -: 3]};
    u.wb  = ins[INSTR_W-6 -: 2];
    beats = 1;
    if (f == 1) begin
      u.rd = ins[INSTR_W-8 -: REG_AW]; u.rs1 = ins[INSTR_W-8-REG_AW -: REG_AW];
      u.rt = 2'b01; u.dt = 1'b1; beats = NB;
    end else if (op == 0 || op == 2 || op == 3) begin
      u.rd = ins[INSTR_W-8 -: REG_AW]; u.imm = ins[IMM_W-1:0]; u.rt = 2'b10;
    end else if (op == 1) begin
      u.rd = ins[INSTR_W-8 -: REG_AW]; u.rs1 = ins[INSTR_W-8-REG_AW -: REG_AW];
      u.rt = 2'b10; u.dt = 1'b1; beats = NB;
    end else if (op == 4 || op == 5 || op == 6) begin
      u.rd  = ins[INSTR_W-8 -: REG_AW];
      u.rs1 = ins[INSTR_W-8-REG_AW -: REG_AW];
      u.rs2 = ins[INSTR_W-8-2*REG_AW -: REG_AW];
      u.rt  = (op == 5) ? 2'b11 : 2'b01;
      u.dt  = 1'b1; beats = NB;
    end else begin
`ifdef VDEC_ILLEGAL_TRAP_EN
      model_err = 1'b1;
      beats = 0;
`else
      u.wb = 2'b00;
`endif
    end
    for (int b = 0; b < beats; b++) begin
      u.beat = BW'(b);
      u.last = (b == beats - 1);
      q.push_back(u);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  task automatic step(input logic iv, input logic [INSTR_W-1:0] ins, input logic ordy);
    logic exp_ir;
    in_valid = iv; instr = ins; out_ready = ordy;
    #1;
    exp_ir = (q.size() == 0) || (q.size() == 1 && ordy);
    check_val("in_ready", 32'(in_ready), 32'(exp_ir));
    check_val("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_val("illegal_err", 32'(illegal_err), 32'(model_err));
    if (q.size() > 0) begin
      check_val("ex_ctrl", 32'(ex_ctrl), 32'(q[0].ex));
      check_val("mem_ctrl", 32'(mem_ctrl), 32'(q[0].mem));
      check_val("wb_ctrl", 32'(wb_ctrl), 32'(q[0].wb));
      check_val("rd", 32'(rd), 32'(q[0].rd));
      check_val("rs1", 32'(rs1), 32'(q[0].rs1));
      check_val("rs2", 32'(rs2), 32'(q[0].rs2));
      check_val("imm", 32'(imm), 32'(q[0].imm));
      check_val("reg_type", 32'(reg_type), 32'(q[0].rt));
      check_val("des_type", 32'(des_type), 32'(q[0].dt));
      check_val("beat_idx", 32'(beat_idx), 32'(q[0].beat));
      check_val("last_beat", 32'(last_beat), 32'(q[0].last));
      if (ordy) void'(q.pop_front());
    end
    if (exp_ir && iv) model_accept(ins);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_err = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_beat_idx", 32'(beat_idx), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_last_beat", 32'(last_beat), 32'd0);
    check_val("rst_rd", 32'(rd), 32'd0);
    check_val("rst_illegal_err", 32'(illegal_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [INSTR_W-1:0] ri;
    repeat (2) @(posedge clk);
    do_reset();

    // MOV imm: single scalar beat one cycle after acceptance
    step(1'b1, mk_imm(0, 3, 3, 'h5A), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // ADD vector-vector: NB beats
    step(1'b1, mk(0, 5, 0, 1, 1, 2, 3), 1'b1);
    for (int i = 0; i < NB + 1; i++) step(1'b0, '0, 1'b1);

    // MUL with out_ready toggling 1,0,0,1
    step(1'b1, mk(0, 4, 0, 1, 5, 6, 7), 1'b1);
    for (int i = 0; i < 4 * NB + 2; i++) step(1'b0, '0, (i % 3) == 0);

    // DIV then SUB imm back to back, in_valid held
    step(1'b1, mk(0, 6, 0, 1, 8, 9, 10), 1'b1);
    for (int i = 0; i < NB; i++) step(1'b1, mk_imm(3, 1, 4, 'hC3), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Load, reset during beat 2
    step(1'b1, mk(1, 2, 0, 2, 11, 12, 0), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();

    // Opcode 111
    step(1'b1, mk(0, 7, 0, 3, 13, 14, 15), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk_imm(2, 1, 2, 'h11), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        ri = INSTR_W'($urandom);
        step($urandom_range(0, 9) < 7, ri, $urandom_range(0, 9) < 7);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vec_decode_seq.md
Name: vec_decode_seq

Overview:
- Registered, parametrised decode-and-issue stage for the vector processor; sits between instruction fetch and the EX stage.
- Decodes one instruction per accepted transfer into EX/MEM/WB control fields, operand register addresses and immediate.
- Vector-destination instructions are sequenced as VLEN/LANES micro-op beats, each tagged with a beat index.
- Both sides use valid/ready handshakes; supersedes the single-cycle combinational control decode.

Parameters:
- INSTR_W, 21, instruction width; must be >= 7+3*REG_AW and >= 7+REG_AW+IMM_W.
- REG_AW, 4, register address width.
- IMM_W, 8, immediate width; the immediate is instr[IMM_W-1:0].
- VLEN, 16, elements per vector register.
- LANES, 4, elements processed per beat; VLEN % LANES == 0 and VLEN/LANES >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction.
- instr  in  INSTR_W  instruction.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  EX accepts micro-op.
- ex_ctrl  out  5  {funct,opcode,imm_flag}.
- mem_ctrl  out  4  {funct,opcode}.
- wb_ctrl  out  2  {sel_mux_wb,reg_write}.
- rd, rs1, rs2  out  REG_AW each  destination and source register addresses.
- imm  out  IMM_W  immediate.
- reg_type  out  2  01 vector-scalar, 10 scalar, 11 vector-vector, 00 none.
- des_type  out  1  1 = vector destination.
- beat_idx  out  $clog2(VLEN/LANES) (min 1)  current beat.
- last_beat  out  1  final beat of the instruction.
- illegal_err  out  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset clears all outputs to 0, puts the FSM in IDLE and clears beat_idx.
- Field layout, MSB first:
  - funct = instr[INSTR_W-1]; opcode = next 3 bits; imm_flag = next bit; wb = next 2 bits.
  - rd = next REG_AW bits, then rs1, then rs2.
  - imm = instr[IMM_W-1:0].
- Decode classes:
  - funct=1 (load/store): rd, rs1 valid; reg_type 01; des_type 1; vector.
  - Opcode 000 (MOV imm), 010 (ADD imm), 011 (SUB imm): rd, imm valid; reg_type 10; des_type 0; scalar.
  - Opcode 001 (MOV scalar to vector): rd, rs1 valid; reg_type 10; des_type 1; vector.
  - Opcode 100 (MUL), 110 (DIV): rd, rs1, rs2 valid; reg_type 01; des_type 1; vector.
  - Opcode 101 (ADD vector-vector): rd, rs1, rs2 valid; reg_type 11; des_type 1; vector.
  - Opcode 111: illegal (see Optional Feature).
  - Unused operand fields are driven to 0.
- Beats: scalar instructions issue 1 beat. Vector instructions issue NB = VLEN/LANES beats with beat_idx 0..NB-1; all other fields are held constant across beats.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid, register the decode, go to ISSUE, beat_idx=0.
  - ISSUE: out_valid=1. On out_ready, if not the last beat, beat_idx+1. On the last beat with out_ready: if in_valid, load the next instruction (back-to-back, no bubble, stay in ISSUE); else go to IDLE.
- Ready and latency:
  - in_ready = (state==IDLE) | (state==ISSUE & last_beat & out_ready). This combinational path from out_ready is permitted.
  - Latency from acceptance to first out_valid is 1 cycle.
- Stall: while out_valid & !out_ready, all outputs hold stable.
- last_beat = (beat_idx == NB-1), and 1 for scalar instructions.
- Reset mid-sequence abandons the remaining beats; the first cycle after reset has out_valid=0.

Optional Feature:
- Macro: VDEC_ILLEGAL_TRAP_EN.
- Defined: opcode 111 is accepted and consumed but no micro-op is issued; illegal_err is set and stays 1 until rst.
- Undefined: opcode 111 issues one scalar micro-op with wb_ctrl=00, reg_type 00 and all register fields 0 (a NOP); illegal_err is tied 0.

Test Plan:
- Reset, then MOV imm (funct0, op000, wb=11, rd=3, imm=0x5A) with out_ready=1 -> one beat with rd=3, imm=0x5A, reg_type=10, des_type=0, last_beat=1 one cycle after acceptance.
- ADD vector-vector (rd=1, rs1=2, rs2=3), out_ready=1 -> 4 consecutive beats, beat_idx 0,1,2,3, last_beat only on beat 3, reg_type=11.
- MUL vector-scalar, out_ready toggling 1,0,0,1,... -> outputs hold during stalls; exactly 4 beats accepted, in_ready=0 until the final handshake.
- Back-to-back DIV then SUB imm with in_valid held -> no idle cycle between DIV beat 3 and SUB beat 0.
- Reset asserted during beat 2 of a load -> next cycle out_valid=0, beat_idx=0, in_ready=1.
- Opcode 111 -> with VDEC_ILLEGAL_TRAP_EN: no out_valid and illegal_err=1 (sticky); without it: one NOP beat with wb_ctrl=00 and illegal_err=0.
